// File: rtl/reg_bank_wr_arbiter.sv
// rtl/reg_bank_wr_arbiter.sv - round-robin write arbiter and clear sequencer for a shared register bank
//
// Grants one of N write requesters per cycle onto a bank of R enable-gated
// registers and runs a timed active-low bank clear after reset or on flush.
//
// Ports:
//   clk        system clock
//   clr        synchronous reset, active high
//   flush      level request for a bank clear sequence (honoured only in RUN)
//   req        per-requester write request
//   wr_addr    per-requester target register index, requester i at [i*AW +: AW]
//   wr_data    per-requester write data, requester i at [i*W +: W]
//   gnt        one-hot grant pulse, one cycle per accepted write
//   bank_ena   one-hot register enable to the bank
//   bank_d     write data to the bank
//   bank_clrn  active-low clear to the bank
//   busy       high while a clear sequence runs
//   addr_err   one-cycle pulse when the granted write addressed a register >= R

module reg_bank_wr_arbiter #(
  parameter int N       = 4,
  parameter int W       = 8,
  parameter int R       = 4,
  parameter int AW      = 4,
  parameter int CLR_CYC = 2
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            flush,
  input  logic [N-1:0]    req,
  input  logic [N*AW-1:0] wr_addr,
  input  logic [N*W-1:0]  wr_data,
  output logic [N-1:0]    gnt,
  output logic [R-1:0]    bank_ena,
  output logic [W-1:0]    bank_d,
  output logic            bank_clrn,
  output logic            busy,
  output logic            addr_err
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(CLR_CYC) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLR_CYC - 1);
  // R always fits in AW+1 bits because 2**AW >= R.
  localparam logic [AW:0] R_LIM = (AW + 1)'(R);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] ptr;
  logic [N-1:0]  mask;

  logic [N-1:0]  elig;
  logic          win_found;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] ptr_next;
  logic [AW-1:0] win_addr;
  logic [W-1:0]  win_data;
  logic          addr_ok;
  logic [N-1:0]  gnt_next;
  logic [R-1:0]  ena_next;
  int            cand;

  // Rotating priority scan starting at ptr; the mask keeps last cycle's
  // winner out so its still-high req cannot cause a duplicate write.
  always_comb begin
    elig      = req & ~mask;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(ptr) + i) % N;
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = PW'(cand);
      end
    end
  end

  always_comb begin
    win_addr = wr_addr[win_idx*AW +: AW];
    win_data = wr_data[win_idx*W +: W];
    addr_ok  = ({1'b0, win_addr} < R_LIM);
    ptr_next = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
    gnt_next = '0;
    for (int n = 0; n < N; n++) begin
      gnt_next[n] = (win_idx == PW'(n));
    end
    ena_next = '0;
    for (int r = 0; r < R; r++) begin
      ena_next[r] = (win_addr == AW'(r));
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= S_CLEAR;
      cnt       <= '0;
      ptr       <= '0;
      mask      <= '0;
      gnt       <= '0;
      bank_ena  <= '0;
      bank_d    <= '0;
      addr_err  <= 1'b0;
      bank_clrn <= 1'b0;
      busy      <= 1'b1;
    end else begin
      gnt      <= '0;
      bank_ena <= '0;
      addr_err <= 1'b0;
      case (state)
        S_CLEAR: begin
          mask <= '0;
          if (cnt == CNT_LAST) begin
            state     <= S_RUN;
            bank_clrn <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          if (flush) begin
            // Flush wins over any pending request in the same cycle.
            state     <= S_CLEAR;
            cnt       <= '0;
            mask      <= '0;
            bank_clrn <= 1'b0;
            busy      <= 1'b1;
          end else if (win_found) begin
            gnt      <= gnt_next;
            bank_d   <= win_data;
            bank_ena <= addr_ok ? ena_next : '0;
            addr_err <= !addr_ok;
            ptr      <= ptr_next;
            mask     <= gnt_next;
          end else begin
            mask <= '0;
          end
        end
        default: begin
          state <= S_CLEAR;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_wr_arbiter.sv
// tb/tb_reg_bank_wr_arbiter.sv - directed self-checking bench for reg_bank_wr_arbiter

module tb_reg_bank_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            clr;
  logic            flush;
  logic [N-1:0]    req;
  logic [N*AW-1:0] wr_addr;
  logic [N*W-1:0]  wr_data;

  logic [N-1:0] gnt;
  logic [3:0]   bank_ena;
  logic [W-1:0] bank_d;
  logic         bank_clrn, busy, addr_err;

  logic [N-1:0] gnt3;
  logic [2:0]   bank_ena3;
  logic [W-1:0] bank_d3;
  logic         bank_clrn3, busy3, addr_err3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reg_bank_wr_arbiter #(.N(N), .W(W), .R(4), .AW(AW), .CLR_CYC(2)) u_dut (
    .clk(clk), .clr(clr), .flush(flush), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
    .gnt(gnt), .bank_ena(bank_ena), .bank_d(bank_d), .bank_clrn(bank_clrn),
    .busy(busy), .addr_err(addr_err)
  );

  reg_bank_wr_arbiter #(.N(N), .W(W), .R(3), .AW(AW), .CLR_CYC(2)) u_dut_r3 (
    .clk(clk), .clr(clr), .flush(flush), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
    .gnt(gnt3), .bank_ena(bank_ena3), .bank_d(bank_d3), .bank_clrn(bank_clrn3),
    .busy(busy3), .addr_err(addr_err3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string tag, input logic [3:0] e_gnt, input logic [3:0] e_ena,
                            input logic [7:0] e_d, input logic e_clrn, input logic e_err);
    check_eq({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    check_eq({tag, ".ena"}, 32'(bank_ena), 32'(e_ena));
    check_eq({tag, ".d"}, 32'(bank_d), 32'(e_d));
    check_eq({tag, ".clrn"}, 32'(bank_clrn), 32'(e_clrn));
    check_eq({tag, ".busy"}, 32'(busy), 32'(!e_clrn));
    check_eq({tag, ".err"}, 32'(addr_err), 32'(e_err));
  endtask

  initial begin
    clr     = 1'b1;
    flush   = 1'b0;
    req     = '0;
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < N; i++) begin
      wr_addr[i*AW +: AW] = AW'(i);
      wr_data[i*W +: W]   = W'(8'h10 + i);
    end

    // Reset, then clear sequence with all requests high.
    tick();
    check_main("reset", 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0);
    check_eq("reset.r3_clrn", 32'(bank_clrn3), 32'd0);
    clr = 1'b0;
    req = 4'b1111;
    tick();
    check_main("clear1", 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0);
    tick();
    check_main("clear_done", 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0);

    // Round robin from ptr=0 with all requesters held high.
    tick();
    check_main("rr0", 4'b0001, 4'b0001, 8'h10, 1'b1, 1'b0);
    tick();
    check_main("rr1", 4'b0010, 4'b0010, 8'h11, 1'b1, 1'b0);
    tick();
    check_main("rr2", 4'b0100, 4'b0100, 8'h12, 1'b1, 1'b0);
    tick();
    check_main("rr3", 4'b1000, 4'b1000, 8'h13, 1'b1, 1'b0);
    check_eq("rr3.r3_gnt", 32'(gnt3), 32'h8);
    check_eq("rr3.r3_ena", 32'(bank_ena3), 32'h0);
    check_eq("rr3.r3_err", 32'(addr_err3), 32'h1);
    tick();
    check_main("rr4", 4'b0001, 4'b0001, 8'h10, 1'b1, 1'b0);
    check_eq("rr4.r3_err", 32'(addr_err3), 32'h0);
    req = 4'b0000;
    tick();
    check_main("idle", 4'b0000, 4'b0000, 8'h10, 1'b1, 1'b0);

    // Solo requester 1: one grant every other cycle.
    req = 4'b0010;
    tick();
    check_main("solo0", 4'b0010, 4'b0010, 8'h11, 1'b1, 1'b0);
    tick();
    check_main("solo1", 4'b0000, 4'b0000, 8'h11, 1'b1, 1'b0);
    tick();
    check_main("solo2", 4'b0010, 4'b0010, 8'h11, 1'b1, 1'b0);
    req = 4'b0000;
    tick();
    check_main("solo3", 4'b0000, 4'b0000, 8'h11, 1'b1, 1'b0);

    // Single write to register 3; out of range for the R=3 instance.
    req                = 4'b0100;
    wr_addr[2*AW +: AW] = 4'd3;
    wr_data[2*W +: W]   = 8'hA5;
    tick();
    check_main("single", 4'b0100, 4'b1000, 8'hA5, 1'b1, 1'b0);
    check_eq("single.r3_gnt", 32'(gnt3), 32'h4);
    check_eq("single.r3_ena", 32'(bank_ena3), 32'h0);
    check_eq("single.r3_err", 32'(addr_err3), 32'h1);
    req = 4'b0000;
    tick();
    check_main("single_after", 4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b0);
    check_eq("single_after.r3_err", 32'(addr_err3), 32'h0);

    // Flush collides with a request; flush held into CLEAR is ignored.
    flush = 1'b1;
    req   = 4'b1000;
    tick();
    check_main("flush0", 4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b0);
    tick();
    check_main("flush1", 4'b0000, 4'b0000, 8'hA5, 1'b0, 1'b0);
    flush = 1'b0;
    tick();
    check_main("flush_done", 4'b0000, 4'b0000, 8'hA5, 1'b1, 1'b0);
    tick();
    check_main("flush_gnt", 4'b1000, 4'b1000, 8'h13, 1'b1, 1'b0);

    // clr mid-operation aborts a write that would otherwise be granted.
    req = 4'b0001;
    clr = 1'b1;
    tick();
    check_main("abort", 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0);
    clr = 1'b0;
    tick();
    check_main("abort_clr1", 4'b0000, 4'b0000, 8'h00, 1'b0, 1'b0);
    tick();
    check_main("abort_done", 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0);
    tick();
    check_main("abort_gnt", 4'b0001, 4'b0001, 8'h10, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_wr_arbiter.md
Name: reg_bank_wr_arbiter

Overview:
- Round-robin write arbiter/sequencer for a shared bank of R enable-gated D registers, each W bits wide.
- Takes write requests from N requesters and grants one per cycle.
- Drives the bank's one-hot per-register enables, shared write data, and the bank's active-low asynchronous clear.
- Issues a timed bank-clear sequence after reset and on demand.

Parameters:
- N, 4, number of requesters (2..8)
- W, 8, register data width
- R, 4, number of registers in the bank (1..16, need not be a power of 2)
- AW, 4, requester address width; must satisfy 2**AW >= R
- CLR_CYC, 2, cycles bank_clrn is held low per clear sequence (>=1)

Ports:
- clk  in  1  system clock
- clr  in  1  synchronous reset, active high
- flush  in  1  request a bank clear sequence (level; sampled only in RUN)
- req  in  N  write request per requester
- wr_addr  in  N*AW  target register index, requester i in bits [i*AW +: AW]
- wr_data  in  N*W  write data, requester i in bits [i*W +: W]
- gnt  out  N  one-hot grant pulse, one cycle per accepted write
- bank_ena  out  R  one-hot register enable to the bank
- bank_d  out  W  write data to the bank
- bank_clrn  out  1  active-low clear to the bank
- busy  out  1  high while a clear sequence runs
- addr_err  out  1  one-cycle pulse: granted write had wr_addr >= R

Behaviour:
- Interface: one clock (clk); reset clr is synchronous and active-high. All outputs are registered.
- Reset (clr=1 at an edge) results:
  - gnt=0, bank_ena=0, bank_d=0, addr_err=0
  - bank_clrn=0, busy=1
  - rr pointer=0, last-grant mask=0
  - FSM enters CLEAR with counter=0
  - clr mid-operation aborts any write: no gnt or ena is issued on the following cycle.
- FSM states:
  - CLEAR:
    - bank_clrn=0, busy=1; no arbitration; gnt and bank_ena held 0.
    - Counter increments each cycle.
    - When counter==CLR_CYC-1, go to RUN next cycle; bank_clrn=1 and busy=0 from that cycle.
  - RUN:
    - Arbitrate every cycle.
    - If flush=1, go to CLEAR (counter=0). flush has priority over pending requests: no grant is issued in that cycle.
- Arbitration (RUN, edge t):
  - Eligible set = req & ~mask.
  - Pick the first eligible index scanning ptr, ptr+1, ..., wrapping mod N.
  - Winner k produces, in cycle t+1:
    - gnt = 1<<k
    - bank_d = wr_data[k]
    - if wr_addr[k] < R: bank_ena = 1<<wr_addr[k], else bank_ena=0 and addr_err=1
    - ptr <= (k+1) mod N
    - mask <= 1<<k
  - No eligible requester: gnt=0, bank_ena=0, ptr unchanged, mask <= 0. bank_d holds its last value.
- Handshake:
  - Requester holds req, wr_addr and wr_data stable until it sees its gnt.
  - The grant cycle is the write cycle: the bank captures at the edge ending it.
  - The one-cycle mask stops a requester's still-high req in its gnt cycle from causing a duplicate write.
  - A requester wanting back-to-back writes sees at best one grant every 2 cycles when alone; other requesters may fill the gap.
- Boundaries:
  - Two requesters targeting the same register in successive grants: both writes occur in grant order.
  - N=1: writes every other cycle.
  - flush while in CLEAR is ignored.
  - req changes in CLEAR are ignored, and no stale grant is issued on exit.

Test Plan:
- Reset/clear: assert clr 1 cycle, CLR_CYC=2 -> bank_clrn=0 and busy=1 for exactly 2 cycles after clr drops, then 1/0; no gnt meanwhile even with req=4'b1111.
- Single write: req[2]=1, wr_addr[2]=3, wr_data[2]=8'hA5 -> next cycle gnt=4'b0100, bank_ena=4'b1000, bank_d=8'hA5; requester drops req -> gnt=0 afterwards.
- Round-robin: req=4'b1111 held constant from ptr=0 -> grants 0,1,2,3,0,... one per cycle, never the same index in consecutive cycles.
- Mask/solo: only req[1] held high -> gnt[1] pulses every other cycle (1,0,1,0), bank_ena likewise.
- Address error: R=3, wr_addr[0]=3 -> gnt[0]=1, bank_ena=0, addr_err=1 for one cycle.
- Flush collision: flush=1 with req[3]=1 in RUN -> no gnt; bank_clrn low for CLR_CYC cycles; then gnt[3] is issued on the first RUN arbitration.
